// File: rtl/pe_array_cfg_ctrl.sv
// PE-array configuration controller: MMIO register file with per-channel DMA
// descriptors, scan-chain ID/LN configuration, sequenced DMA with a watchdog,
// abort, sticky done/error status and config locking while busy.
module pe_array_cfg_ctrl #(
  parameter int unsigned NUMS_PE_ROW    = 6,
  parameter int unsigned NUMS_PE_COL    = 8,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE = ADDR_WIDTH'(32'h1000_0000),
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned LEN_BITS       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  localparam int unsigned NUM_PE        = NUMS_PE_ROW * NUMS_PE_COL,
  localparam int unsigned IDX_W         = $clog2(NUM_PE)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_mmio_we,
  input  logic [ADDR_WIDTH-1:0]  i_mmio_w_addr,
  input  logic [31:0]            i_mmio_w_data,
  input  logic [ADDR_WIDTH-1:0]  i_mmio_r_addr,
  output logic [31:0]            o_mmio_r_data,
  output logic                   o_dma_start,
  output logic [ADDR_WIDTH-1:0]  o_dma_src_addr,
  output logic [ADDR_WIDTH-1:0]  o_dma_dst_addr,
  output logic [LEN_BITS-1:0]    o_dma_length,
  input  logic                   i_dma_done,
  output logic [IDX_W-1:0]       o_id_idx,
  output logic                   o_set_XID,
  output logic                   o_set_YID,
  output logic                   o_set_LN,
  output logic [NUMS_PE_ROW-2:0] o_LN_config_in,
  output logic                   o_busy,
  output logic                   o_irq
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CH_W-1:0]       LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_PE - 1);
  localparam logic [WD_W-1:0]       WD_LIMIT   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_CTRL   = ADDR_WIDTH'(32'h00);
  localparam logic [ADDR_WIDTH-1:0] OFF_STATUS = ADDR_WIDTH'(32'h04);
  localparam logic [ADDR_WIDTH-1:0] OFF_LN     = ADDR_WIDTH'(32'h08);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK   = ADDR_WIDTH'(32'h0C);

  typedef enum logic [2:0] {
    StIdle, StScan, StDmaSel, StDmaReq, StDmaWait, StFinish
  } state_e;

  // Descriptor k (0=SRC, 1=DST, 2=LEN) of channel c.
  function automatic logic [ADDR_WIDTH-1:0] desc_off(input int unsigned c, input int unsigned k);
    return ADDR_WIDTH'(32'h10 + 12 * c + 4 * k);
  endfunction

  state_e                  r_state, w_state_nxt;
  logic [IDX_W-1:0]        r_idx, w_idx_nxt;
  logic [CH_W-1:0]         r_ch, w_ch_nxt;
  logic [WD_W-1:0]         r_wd, w_wd_nxt;
  logic [NUMS_PE_ROW-2:0]  r_ln_cfg;
  logic [NUM_CH-1:0]       r_ch_mask;
  logic [ADDR_WIDTH-1:0]   r_src [NUM_CH];
  logic [ADDR_WIDTH-1:0]   r_dst [NUM_CH];
  logic [LEN_BITS-1:0]     r_len [NUM_CH];
  logic                    r_done, r_error;

  logic [ADDR_WIDTH-1:0]   w_w_off, w_r_off;
  logic                    w_busy, w_ctrl_we, w_start, w_abort, w_status_we, w_cfg_we;
  logic                    w_set_done, w_set_error;

  assign w_w_off     = i_mmio_w_addr - MMIO_BASE;
  assign w_r_off     = i_mmio_r_addr - MMIO_BASE;
  assign w_busy      = (r_state != StIdle);
  assign w_ctrl_we   = i_mmio_we && (w_w_off == OFF_CTRL);
  // ABORT outranks START when both bits are written together.
  assign w_abort     = w_ctrl_we && i_mmio_w_data[1];
  assign w_start     = w_ctrl_we && i_mmio_w_data[0] && !i_mmio_w_data[1];
  assign w_status_we = i_mmio_we && (w_w_off == OFF_STATUS);
  // Configuration is frozen while an operation runs.
  assign w_cfg_we    = i_mmio_we && !w_busy;

  assign o_busy = w_busy;
  assign o_irq  = r_done | r_error;

  // Register file writes and sticky status bits (set wins over clear).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ln_cfg  <= '0;
      r_ch_mask <= '0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_src[c] <= '0;
        r_dst[c] <= '0;
        r_len[c] <= '0;
      end
    end else begin
      if (w_cfg_we) begin
        if (w_w_off == OFF_LN)   r_ln_cfg  <= i_mmio_w_data[NUMS_PE_ROW-2:0];
        if (w_w_off == OFF_MASK) r_ch_mask <= i_mmio_w_data[NUM_CH-1:0];
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (w_w_off == desc_off(c, 0)) r_src[c] <= ADDR_WIDTH'(i_mmio_w_data);
          if (w_w_off == desc_off(c, 1)) r_dst[c] <= ADDR_WIDTH'(i_mmio_w_data);
          if (w_w_off == desc_off(c, 2)) r_len[c] <= i_mmio_w_data[LEN_BITS-1:0];
        end
      end
      if (w_set_done)                               r_done  <= 1'b1;
      else if (w_status_we && i_mmio_w_data[1])     r_done  <= 1'b0;
      if (w_set_error)                              r_error <= 1'b1;
      else if (w_status_we && i_mmio_w_data[2])     r_error <= 1'b0;
    end
  end

  // FSM state and counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
      r_ch    <= '0;
      r_wd    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_ch    <= w_ch_nxt;
      r_wd    <= w_wd_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_ch_nxt    = r_ch;
    w_wd_nxt    = r_wd;
    w_set_done  = 1'b0;
    w_set_error = 1'b0;
    if (w_abort && w_busy) begin
      w_state_nxt = StIdle;
      w_set_error = 1'b1;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_start) begin
            w_state_nxt = StScan;
            w_idx_nxt   = '0;
          end
        end
        StScan: begin
          if (r_idx == LAST_IDX) begin
            w_state_nxt = StDmaSel;
            w_ch_nxt    = '0;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
        StDmaSel: begin
          if (r_ch_mask[r_ch] && (r_len[r_ch] != '0)) begin
            w_state_nxt = StDmaReq;
          end else if (r_ch == LAST_CH) begin
            w_state_nxt = StFinish;
          end else begin
            w_ch_nxt = r_ch + CH_W'(1);
          end
        end
        StDmaReq: begin
          // Watchdog counts cycles since the dma_start pulse.
          w_wd_nxt    = WD_W'(1);
          w_state_nxt = StDmaWait;
        end
        StDmaWait: begin
          if (i_dma_done) begin
            if (r_ch == LAST_CH) begin
              w_state_nxt = StFinish;
            end else begin
              w_ch_nxt    = r_ch + CH_W'(1);
              w_state_nxt = StDmaSel;
            end
          end else if (r_wd >= WD_LIMIT) begin
            w_state_nxt = StIdle;
            w_set_error = 1'b1;
          end else begin
            w_wd_nxt = r_wd + WD_W'(1);
          end
        end
        StFinish: begin
          w_set_done  = 1'b1;
          w_state_nxt = StIdle;
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  // Scan-chain and DMA outputs, zero outside their phases.
  always_comb begin
    o_set_XID      = 1'b0;
    o_set_YID      = 1'b0;
    o_set_LN       = 1'b0;
    o_id_idx       = '0;
    o_LN_config_in = '0;
    o_dma_start    = 1'b0;
    o_dma_src_addr = '0;
    o_dma_dst_addr = '0;
    o_dma_length   = '0;
    case (r_state)
      StScan: begin
        o_set_XID      = 1'b1;
        o_set_YID      = (r_idx < IDX_W'(NUMS_PE_ROW));
        o_set_LN       = (r_idx == '0);
        o_id_idx       = r_idx;
        o_LN_config_in = r_ln_cfg;
      end
      StDmaReq, StDmaWait: begin
        o_dma_start    = (r_state == StDmaReq);
        o_dma_src_addr = r_src[r_ch];
        o_dma_dst_addr = r_dst[r_ch];
        o_dma_length   = r_len[r_ch];
      end
      default: ;
    endcase
  end

  // Combinational MMIO read mux; CTRL and unmapped offsets read 0.
  always_comb begin
    o_mmio_r_data = '0;
    if (w_r_off == OFF_STATUS) o_mmio_r_data = {29'd0, r_error, r_done, w_busy};
    if (w_r_off == OFF_LN)     o_mmio_r_data = 32'(r_ln_cfg);
    if (w_r_off == OFF_MASK)   o_mmio_r_data = 32'(r_ch_mask);
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (w_r_off == desc_off(c, 0)) o_mmio_r_data = 32'(r_src[c]);
      if (w_r_off == desc_off(c, 1)) o_mmio_r_data = 32'(r_dst[c]);
      if (w_r_off == desc_off(c, 2)) o_mmio_r_data = 32'(r_len[c]);
    end
  end

endmodule

// File: doc/pe_array_cfg_ctrl.md
Name: pe_array_cfg_ctrl

Overview:
Parametrised next-generation PE-array controller. It holds an MMIO register file with per-channel DMA descriptors and runs three phases: ID/LN scan-chain configuration, sequenced DMA transfers over up to NUM_CH channels, and completion reporting. It adds abort, a DMA watchdog, a sticky status register and configuration locking while busy. It sits between the CPU MMIO bus, the DMA engine and the PE-array scan chains.

Parameters:
NUMS_PE_ROW, 6, PE array rows
NUMS_PE_COL, 8, PE array columns
ADDR_WIDTH, 32, MMIO and DMA address width
MMIO_BASE, 32'h1000_0000, base byte address of the register file
NUM_CH, 4, number of DMA descriptor channels (1..8)
LEN_BITS, 16, DMA length width
TIMEOUT_CYCLES, 4096, maximum number of cycles to wait for dma_done

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mmio_we  in  1  MMIO write strobe
mmio_w_addr  in  ADDR_WIDTH  write byte address
mmio_w_data  in  32  write data
mmio_r_addr  in  ADDR_WIDTH  read byte address
mmio_r_data  out  32  read data (combinational)
dma_start  out  1  one-cycle DMA request pulse
dma_src_addr  out  ADDR_WIDTH  DMA source address
dma_dst_addr  out  ADDR_WIDTH  DMA destination address
dma_length  out  LEN_BITS  DMA length
dma_done  in  1  DMA completion pulse
id_idx  out  clog2(ROW*COL)  PE index into the external ID table
set_XID  out  1  XID scan shift enable
set_YID  out  1  YID scan shift enable
set_LN  out  1  LN config load
LN_config_in  out  NUMS_PE_ROW-1  LN configuration bits
busy  out  1  operation in progress
irq  out  1  level interrupt, equal to done OR error

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: every output is 0, every register is 0, and the FSM is in IDLE.
- Register map (byte offsets from MMIO_BASE):
  - 0x00 CTRL: bit0 START (write 1 to start, self-clearing, reads 0); bit1 ABORT (write 1, reads 0).
  - 0x04 STATUS: bit0 busy (read-only); bit1 done (sticky); bit2 error (sticky). Writing 1 to bit1 or bit2 clears that bit.
  - 0x08 LN_CFG: bits [NUMS_PE_ROW-2:0].
  - 0x0C CH_MASK: bits [NUM_CH-1:0].
  - 0x10+12*c: SRC[c]. 0x14+12*c: DST[c]. 0x18+12*c: LEN[c], bits [LEN_BITS-1:0].
  - Unmapped reads return 0. Unmapped writes are ignored.
- Lock: while busy, writes to LN_CFG, CH_MASK and the descriptor registers are ignored. Only CTRL.ABORT and STATUS writes are honoured.
- FSM states: IDLE, SCAN, DMA_SEL, DMA_REQ, DMA_WAIT, FINISH.
  - IDLE: a START write moves to SCAN on the next cycle, sets busy and clears idx to 0. A START write while busy is ignored.
  - SCAN: set_XID=1 every cycle. id_idx=idx. set_YID=1 while idx<NUMS_PE_ROW. set_LN=1 only when idx==0. LN_config_in=LN_CFG throughout. The state lasts exactly ROW*COL cycles, then goes to DMA_SEL with ch=0.
  - DMA_SEL: if CH_MASK[ch]=1 and LEN[ch]!=0, go to DMA_REQ. Otherwise increment ch. After ch==NUM_CH-1 has been evaluated, go to FINISH. Each evaluated channel costs one cycle.
  - DMA_REQ: dma_start=1 for exactly one cycle, then go to DMA_WAIT. Clear the watchdog.
  - DMA_WAIT: dma_src_addr, dma_dst_addr and dma_length hold SRC[ch], DST[ch], LEN[ch] from the DMA_REQ cycle until dma_done. On dma_done, increment ch and go to DMA_SEL, or to FINISH if ch==NUM_CH-1. The watchdog increments each cycle. When it reaches TIMEOUT_CYCLES without dma_done, set error and go to IDLE.
  - FINISH: set done, clear busy, go to IDLE. Lasts one cycle.
- dma_done arriving outside DMA_WAIT is ignored. dma_done arriving in the same cycle the watchdog expires counts as completion.
- ABORT while busy: on the next cycle the FSM goes to IDLE, busy clears, error sets and done is unchanged. ABORT in IDLE has no effect.
- ABORT and START written in the same cycle: ABORT wins.
- An all-zero CH_MASK, or all lengths zero: SCAN, then NUM_CH DMA_SEL cycles, then FINISH.
- rst mid-operation: next cycle is the full reset state. dma_start is never asserted in the cycle after rst.
- DMA outputs are 0 outside DMA_REQ and DMA_WAIT. Scan outputs are 0 outside SCAN.

Test Plan:
- Reset, then read all registers -> all 0, busy=0, irq=0. Write 0xDEAD to 0x200 (unmapped) -> reads 0.
- ROW=6, COL=8, LN_CFG=5'b10101, CH_MASK=0, START -> set_XID high for 48 cycles with id_idx 0..47; set_YID high for the first 6 cycles; set_LN high for 1 cycle; FINISH at cycle 48+4+1; STATUS=0b010; irq=1.
- CH_MASK=4'b0101, SRC0=0x100, DST0=0x2000, LEN0=64, SRC2=0x300, LEN2=16, dma_done 10 cycles after each start -> exactly two dma_start pulses with the programmed values held stable; LEN1 is never used; done=1.
- Write CH_MASK=0xF while busy -> the register read returns the old value. Write STATUS=0b010 after done -> STATUS reads 0 and irq=0.
- TIMEOUT_CYCLES=16, dma_done never asserted -> error=1, busy=0 exactly 16 cycles after dma_start. Pulse dma_done in IDLE afterwards -> no state change.
- ABORT in DMA_WAIT -> IDLE next cycle, error=1, done=0. START and ABORT in the same write (CTRL=0b11) while idle -> no operation starts. Assert rst in SCAN -> all outputs 0 next cycle.
